// File: rtl/key_debounce_if.sv
// key_debounce_if: bundles the raw key line with the debounced level and
// change flag. The master side is the board/button (or a bench). The slave
// side is the debouncer.
interface key_debounce_if;
   logic key_raw;
   logic key_level;
   logic key_changed;

   modport master (
      output key_raw,
      input  key_level,
      input  key_changed
   );

   modport slave (
      input  key_raw,
      output key_level,
      output key_changed
   );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchronizes a raw pushbutton/switch line into the clk domain.
// It rejects contact bounce with a stability counter and presents a clean
// active-high level plus a one-cycle change flag to the single-pulse stage.
//
// Optional feature macro: KEY_DEBOUNCE_REPEAT_EN
//   When it is defined, a held key (STABLE_HIGH) gets a one-cycle low gap in
//   key_level every REPEAT_CYCLES cycles. The downstream stage then re-fires
//   while the key is held. key_changed never pulses for these gaps.
module key_debounce #(
   parameter int STABLE_CYCLES = 4,
   parameter int ACTIVE_LOW_IN = 1,
   parameter int REPEAT_CYCLES = 8
) (
   input logic           clk,
   input logic           Reset,
   key_debounce_if.slave kif
);

   localparam int CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Both counts need at least two cycles. Smaller values would make the
   // counter widths degenerate.
   if (STABLE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
      $error("key_debounce: STABLE_CYCLES and REPEAT_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {
      STABLE_LOW,
      PEND_HIGH,
      STABLE_HIGH,
      PEND_LOW
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             level_q, level_d;
   logic             changed_q, changed_d;
   logic             key_in;

`ifdef KEY_DEBOUNCE_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_CYCLES);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

   logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

   assign key_in          = (ACTIVE_LOW_IN != 0) ? ~kif.key_raw : kif.key_raw;
   assign kif.key_level   = level_q;
   assign kif.key_changed = changed_q;

   // Next-state logic: a two-flop synchronizer feeds a four-state stability
   // FSM. The output level flips only after STABLE_CYCLES agreeing samples.
   always_comb begin
      s1_d      = key_in;
      s2_d      = s1_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      changed_d = 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rpt_d     = '0;
`endif

      case (state_q)
         STABLE_LOW: begin
            level_d = 1'b0;
            if (s2_q) begin
               state_d = PEND_HIGH;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end

         PEND_HIGH: begin
            if (!s2_q) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = STABLE_HIGH;
               cnt_d     = '0;
               level_d   = 1'b1;
               changed_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         STABLE_HIGH: begin
            level_d = 1'b1;
            if (!s2_q) begin
               state_d = PEND_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
               if (rpt_q == RPT_LAST) begin
                  level_d = 1'b0;
                  rpt_d   = '0;
               end else begin
                  rpt_d = rpt_q + RPT_W'(1);
               end
`endif
            end
         end

         PEND_LOW: begin
            level_d = 1'b1;
            if (s2_q) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = STABLE_LOW;
               cnt_d     = '0;
               level_d   = 1'b0;
               changed_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   // All state registers. A synchronous active-low reset discards any pending
   // count, so a key held through reset is re-qualified from scratch.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         state_q   <= STABLE_LOW;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         changed_q <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
         rpt_q     <= '0;
`endif
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         changed_q <= changed_d;
`ifdef KEY_DEBOUNCE_REPEAT_EN
         rpt_q     <= rpt_d;
`endif
      end
   end

endmodule
